// File: rtl/spike_event_arbiter.sv
// Round-robin serialiser for neuron onset/offset spikes. Each neuron keeps one pending
// slot per event type so events survive output backpressure; the output is a valid/ready register.
module spike_event_arbiter #(
    parameter int NUM_NEURONS = 8,
    parameter int ID_WIDTH    = 3,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_NEURONS-1:0] spike_valid,
    input  logic [NUM_NEURONS-1:0] spike_on_off,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_WIDTH-1:0]    out_id,
    output logic                   out_on_off,
    output logic [DROP_WIDTH-1:0]  drop_count,
    input  logic                   drop_clear
);

    localparam int CNT_W = $clog2(NUM_NEURONS + 1);

    logic [NUM_NEURONS-1:0] pend_on, pend_off, first_off, req;
    logic [NUM_NEURONS-1:0] pend_on_nx, pend_off_nx, first_off_nx;
    logic [ID_WIDTH-1:0]    ptr, ptr_next, gnt_id, scan_idx;
    logic                   gnt_found, gnt_type, load;
    logic [CNT_W-1:0]       drop_num;
    logic [DROP_WIDTH-1:0]  drop_nx;

    function automatic logic [DROP_WIDTH-1:0] sat_add(input logic [DROP_WIDTH-1:0] base,
                                                      input logic [CNT_W-1:0] inc);
        logic [DROP_WIDTH:0] sum;
        sum = {1'b0, base} + (DROP_WIDTH+1)'(inc);
        return sum[DROP_WIDTH] ? '1 : sum[DROP_WIDTH-1:0];
    endfunction

    assign req  = pend_on | pend_off;
    assign load = (!out_valid || out_ready) && (|req);

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = ptr;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (!gnt_found && req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
            scan_idx = (scan_idx == ID_WIDTH'(NUM_NEURONS - 1)) ? '0 : scan_idx + ID_WIDTH'(1);
        end
        // When both slots are full the older one goes first.
        gnt_type = (pend_on[gnt_id] && pend_off[gnt_id]) ? !first_off[gnt_id] : pend_on[gnt_id];
        ptr_next = (gnt_id == ID_WIDTH'(NUM_NEURONS - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
    end

    always_comb begin
        pend_on_nx   = pend_on;
        pend_off_nx  = pend_off;
        first_off_nx = first_off;
        drop_num     = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (load && gnt_id == ID_WIDTH'(i)) begin
                if (gnt_type) begin
                    pend_on_nx[i]   = 1'b0;
                    first_off_nx[i] = 1'b1;
                end else begin
                    pend_off_nx[i]  = 1'b0;
                    first_off_nx[i] = 1'b0;
                end
            end
            // A slot freed by this cycle's grant can take the new event immediately.
            if (spike_valid[i]) begin
                if (spike_on_off[i]) begin
                    if (pend_on_nx[i]) begin
                        drop_num = drop_num + CNT_W'(1);
                    end else begin
                        pend_on_nx[i] = 1'b1;
                        if (!pend_off_nx[i]) first_off_nx[i] = 1'b0;
                    end
                end else begin
                    if (pend_off_nx[i]) begin
                        drop_num = drop_num + CNT_W'(1);
                    end else begin
                        pend_off_nx[i] = 1'b1;
                        if (!pend_on_nx[i]) first_off_nx[i] = 1'b1;
                    end
                end
            end
        end
        drop_nx = sat_add(drop_clear ? '0 : drop_count, drop_num);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_on    <= '0;
            pend_off   <= '0;
            first_off  <= '0;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_on_off <= 1'b0;
            drop_count <= '0;
        end else begin
            pend_on    <= pend_on_nx;
            pend_off   <= pend_off_nx;
            first_off  <= first_off_nx;
            drop_count <= drop_nx;
            if (load) begin
                out_valid  <= 1'b1;
                out_id     <= gnt_id;
                out_on_off <= gnt_type;
                ptr        <= ptr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
